// File: rtl/fetch_bpred.sv
// rtl/fetch_bpred.sv - IF-stage PC generator with direct-mapped BTB and 2-bit direction counters
// Optional branch/mispredict statistics counters: define BPRED_STATS_EN.
module fetch_bpred #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        StallF,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_branch,
    input  logic [31:0] i_ex_pc,
    input  logic        i_ex_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_pred_target,
    output logic [31:0] pc,
    output logic [31:0] pc_four,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    output logic        o_mispredict
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
`endif
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]      btb_target [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             res;
    logic [31:0]      redirect_pc;
    logic [31:0]      next_pc;

    always_comb begin
        lk_idx        = pc[IDX_W+1:2];
        lk_tag        = pc[31:IDX_W+2];
        lk_hit        = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
        pc_four       = pc + 32'd4;
        o_pred_taken  = lk_hit && btb_ctr[lk_idx][1];
        o_pred_target = o_pred_taken ? btb_target[lk_idx] : 32'd0;
    end

    always_comb begin
        ex_idx       = i_ex_pc[IDX_W+1:2];
        ex_tag       = i_ex_pc[31:IDX_W+2];
        ex_hit       = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
        res          = i_ex_valid && i_ex_is_branch;
        o_mispredict = res && ((i_ex_taken != i_ex_pred_taken) ||
                               (i_ex_taken && (i_ex_target != i_ex_pred_target)));
        redirect_pc  = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);
    end

    // A resolved mispredict beats the stall: the stalled fetch is on the wrong path anyway.
    always_comb begin
        if (o_mispredict) begin
            next_pc = redirect_pc;
        end else if (StallF) begin
            next_pc = pc;
        end else if (o_pred_taken) begin
            next_pc = o_pred_target;
        end else begin
            next_pc = pc_four;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc <= RESET_PC;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= 32'd0;
                btb_ctr[i]    <= 2'b01;
            end
        end else begin
            pc <= next_pc;
            if (res) begin
                if (ex_hit) begin
                    if (i_ex_taken) begin
                        btb_target[ex_idx] <= i_ex_target;
                        if (btb_ctr[ex_idx] != 2'b11) begin
                            btb_ctr[ex_idx] <= btb_ctr[ex_idx] + 2'd1;
                        end
                    end else if (btb_ctr[ex_idx] != 2'b00) begin
                        btb_ctr[ex_idx] <= btb_ctr[ex_idx] - 2'd1;
                    end
                end else if (i_ex_taken) begin
                    // New taken branch starts weakly taken so it predicts on its next fetch.
                    btb_valid[ex_idx]  <= 1'b1;
                    btb_tag[ex_idx]    <= ex_tag;
                    btb_target[ex_idx] <= i_ex_target;
                    btb_ctr[ex_idx]    <= 2'b10;
                end
            end
        end
    end

`ifdef BPRED_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_br_cnt      <= 32'd0;
            o_mispred_cnt <= 32'd0;
        end else begin
            if (res) begin
                o_br_cnt <= o_br_cnt + 32'd1;
            end
            if (o_mispredict) begin
                o_mispred_cnt <= o_mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_bpred.sv
// tb/tb_fetch_bpred.sv - directed self-checking bench for fetch_bpred
module tb_fetch_bpred;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        StallF;
    logic        i_ex_valid;
    logic        i_ex_is_branch;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        o_mispredict;
`ifdef BPRED_STATS_EN
    logic [31:0] o_br_cnt;
    logic [31:0] o_mispred_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int exp_br  = 0;
    int exp_mis = 0;

    always #5 i_clk = ~i_clk;

    fetch_bpred #(.BTB_ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .StallF           (StallF),
        .i_ex_valid       (i_ex_valid),
        .i_ex_is_branch   (i_ex_is_branch),
        .i_ex_pc          (i_ex_pc),
        .i_ex_taken       (i_ex_taken),
        .i_ex_target      (i_ex_target),
        .i_ex_pred_taken  (i_ex_pred_taken),
        .i_ex_pred_target (i_ex_pred_target),
        .pc               (pc),
        .pc_four          (pc_four),
        .o_pred_taken     (o_pred_taken),
        .o_pred_target    (o_pred_target),
        .o_mispredict     (o_mispredict)
`ifdef BPRED_STATS_EN
        ,
        .o_br_cnt         (o_br_cnt),
        .o_mispred_cnt    (o_mispred_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_ex;
        i_ex_valid       = 1'b0;
        i_ex_is_branch   = 1'b0;
        i_ex_pc          = 32'd0;
        i_ex_taken       = 1'b0;
        i_ex_target      = 32'd0;
        i_ex_pred_taken  = 1'b0;
        i_ex_pred_target = 32'd0;
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
        clear_ex();
    endtask

    task automatic resolve(input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptg, input logic exp_m);
        i_ex_valid       = 1'b1;
        i_ex_is_branch   = 1'b1;
        i_ex_pc          = epc;
        i_ex_taken       = tk;
        i_ex_target      = tgt;
        i_ex_pred_taken  = pt;
        i_ex_pred_target = ptg;
        #1;
        chk("mispredict", {31'd0, o_mispredict}, {31'd0, exp_m});
        exp_br++;
        if (exp_m) exp_mis++;
    endtask

    // Steer fetch to a: a not-taken branch at a-4 that was predicted taken.
    task automatic redirect_to(input logic [31:0] a);
        resolve(a - 32'd4, 1'b0, 32'd0, 1'b1, 32'd0, 1'b1);
        step();
        chk("redirect_pc", pc, a);
    endtask

    initial begin
        i_rst_n = 1'b0;
        StallF  = 1'b0;
        clear_ex();

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_four", pc_four, 32'h4);
        chk("rst_pred_taken", {31'd0, o_pred_taken}, 32'd0);
        chk("rst_pred_target", o_pred_target, 32'h0);
        i_rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("seq_pc", pc, 32'(4 * k));
            chk("seq_pred", {31'd0, o_pred_taken}, 32'd0);
        end

        resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        step();
        chk("alloc_redirect", pc, 32'h40);
        chk("alloc_other_idx", {31'd0, o_pred_taken}, 32'd0);
        redirect_to(32'h10);
        chk("alloc_pred", {31'd0, o_pred_taken}, 32'd1);
        chk("alloc_target", o_pred_target, 32'h40);
        step();
        chk("pred_follow", pc, 32'h40);

        resolve(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        redirect_to(32'h10);
        chk("ctr01_pred", {31'd0, o_pred_taken}, 32'd0);
        chk("ctr01_target", o_pred_target, 32'h0);
        resolve(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        resolve(32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        step();
        redirect_to(32'h10);
        chk("ctr_sat_low", {31'd0, o_pred_taken}, 32'd0);
        resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        step();
        redirect_to(32'h10);
        chk("ctr10_pred", {31'd0, o_pred_taken}, 32'd1);

        StallF = 1'b1;
        step();
        chk("stall_hold", pc, 32'h10);
        resolve(32'h20, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
        step();
        chk("stall_redirect", pc, 32'h80);
        step();
        chk("stall_hold2", pc, 32'h80);
        StallF = 1'b0;
        step();
        chk("unstall", pc, 32'h84);

        redirect_to(32'h50);
        chk("alias_miss", {31'd0, o_pred_taken}, 32'd0);
        resolve(32'h50, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        step();
        chk("alias_redirect", pc, 32'h100);
        redirect_to(32'h10);
        chk("alias_replaced", {31'd0, o_pred_taken}, 32'd0);
        redirect_to(32'h50);
        chk("alias_new_pred", {31'd0, o_pred_taken}, 32'd1);
        chk("alias_new_target", o_pred_target, 32'h100);

        resolve(32'h50, 1'b1, 32'hC0, 1'b1, 32'h40, 1'b1);
        chk("same_cycle_old_target", o_pred_target, 32'h100);
        step();
        chk("wrong_target_pc", pc, 32'hC0);
        redirect_to(32'h50);
        chk("target_updated", o_pred_target, 32'hC0);
        resolve(32'h50, 1'b1, 32'hC0, 1'b1, 32'hC0, 1'b0);
        step();
        chk("correct_pred_pc", pc, 32'hC0);

        i_ex_valid = 1'b0; i_ex_is_branch = 1'b1; i_ex_pc = 32'h30;
        i_ex_taken = 1'b1; i_ex_target = 32'h200;
        #1;
        chk("novalid_mispredict", {31'd0, o_mispredict}, 32'd0);
        step();
        i_ex_valid = 1'b1; i_ex_is_branch = 1'b0; i_ex_pc = 32'h30;
        i_ex_taken = 1'b1; i_ex_target = 32'h200;
        #1;
        chk("nobranch_mispredict", {31'd0, o_mispredict}, 32'd0);
        step();
        redirect_to(32'h30);
        chk("no_alloc", {31'd0, o_pred_taken}, 32'd0);

        redirect_to(32'hFFFF_FFFC);
        chk("pc_four_wrap", pc_four, 32'h0);
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        step();
        chk("ex_pc_wrap", pc, 32'h0);
        redirect_to(32'hFFFF_FFFC);
        step();
        chk("pc_wrap", pc, 32'h0);

`ifdef BPRED_STATS_EN
        chk("br_cnt", o_br_cnt, 32'(exp_br));
        chk("mispred_cnt", o_mispred_cnt, 32'(exp_mis));
`endif

        i_rst_n = 1'b0;
        i_ex_valid = 1'b1; i_ex_is_branch = 1'b1; i_ex_pc = 32'h60;
        i_ex_taken = 1'b1; i_ex_target = 32'h200;
        step();
        chk("reset_discards_redirect", pc, 32'h0);
`ifdef BPRED_STATS_EN
        chk("rst_br_cnt", o_br_cnt, 32'd0);
        chk("rst_mispred_cnt", o_mispred_cnt, 32'd0);
`endif
        i_rst_n = 1'b1;
        redirect_to(32'h60);
        chk("reset_discards_update", {31'd0, o_pred_taken}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
